// File: rtl/boot_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : boot_reader_if
// Purpose  : Bundles the boot-memory read port and the output word stream of
//            the boot readback engine.
// Signals  : mem_rd_en / mem_addr  - single-word read strobe and word address
//            mem_rdata             - read data, valid one cycle after strobe
//            dout_valid/dout_data  - output stream word
//            dout_ready            - stream consumer accept
// Modports : master - engine side (drives reads and stream)
//            slave  - memory + consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface boot_reader_if #(
  parameter int MEM_AW = 16,
  parameter int DATA_W = 32
);
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              dout_valid;
  logic [DATA_W-1:0] dout_data;
  logic              dout_ready;

  modport master (
    output mem_rd_en, mem_addr, dout_valid, dout_data,
    input  mem_rdata, dout_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, dout_valid, dout_data,
    output mem_rdata, dout_ready
  );
endinterface
`default_nettype wire

// File: rtl/boot_reader.sv
`default_nettype none
// ============================================================================
// Module   : boot_reader
// Purpose  : Boot-path readback engine. Accepts a descriptor (block address,
//            word length), issues sequential single-word reads to a
//            fixed-latency (1 cycle) boot memory and streams the words out
//            through a small FIFO that absorbs latency and backpressure.
// Ports    : clk     - clock, rising edge
//            clr     - synchronous active-high reset
//            start   - transfer request, sampled only when idle
//            addr_i  - descriptor block address
//            len_i   - descriptor length in words
//            busy    - engine not idle
//            done    - one-cycle pulse on normal completion
//            err     - one-cycle pulse on a rejected descriptor
//            bus     - memory read port + output stream (master modport)
// Revision : 1.0 - initial release
// ============================================================================
module boot_reader #(
  parameter int MEM_AW    = 16,
  parameter int DATA_W    = 32,
  parameter int BLK_SHIFT = 8,
  parameter int DEPTH     = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [7:0]    addr_i,
  input  logic [31:0]   len_i,
  output logic          busy,
  output logic          done,
  output logic          err,
  boot_reader_if.master bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_SH_W  = BLK_SHIFT + 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [MEM_AW-1:0]   r_rd_ptr;
  logic [31:0]         r_remaining;
  logic                r_inflight;

  logic [DATA_W-1:0]   r_fifo [DEPTH];
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_PTR_W:0]    r_count;

  logic [c_SH_W-1:0]   w_shifted;
  logic [MEM_AW-1:0]   w_base;
  logic [33:0]         w_end;
  logic [33:0]         w_limit;
  logic                w_reject;
  logic [c_PTR_W+1:0]  w_occ;
  logic                w_rd_en;
  logic                w_push;
  logic                w_pop;
  logic                w_accept;

  // --------------------------------------------------------------------------
  // Descriptor decode: block address scaled to a word address, then checked
  // against the top of the memory using a 34-bit sum so nothing wraps.
  // --------------------------------------------------------------------------
  assign w_shifted = c_SH_W'(addr_i) << BLK_SHIFT;

  if (MEM_AW >= c_SH_W) begin : g_base_ext
    assign w_base = MEM_AW'(w_shifted);
  end else begin : g_base_trunc
    assign w_base = w_shifted[MEM_AW-1:0];
  end

  assign w_end    = 34'(w_base) + 34'(len_i);
  assign w_limit  = 34'(1) << MEM_AW;
  assign w_reject = (w_end > w_limit);
  assign w_accept = (r_state == S_IDLE) && start;

  // --------------------------------------------------------------------------
  // Read issue: a read is allowed only if the FIFO is guaranteed a free slot
  // when its data returns. A pop in the same cycle is deliberately not
  // credited, which keeps the issue logic independent of dout_ready.
  // --------------------------------------------------------------------------
  assign w_occ   = (c_PTR_W+2)'(r_count) + (c_PTR_W+2)'(r_inflight);
  assign w_rd_en = (r_state == S_FETCH) && (r_remaining != 32'd0) &&
                   (w_occ < (c_PTR_W+2)'(DEPTH));

  assign w_push  = r_inflight;
  assign w_pop   = (r_count != '0) && bus.dout_ready;

  assign bus.mem_rd_en  = w_rd_en;
  assign bus.mem_addr   = w_rd_en ? r_rd_ptr : '0;
  assign bus.dout_valid = (r_count != '0);
  assign bus.dout_data  = r_fifo[r_rptr];

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign err  = (r_state == S_ERR);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len_i == 32'd0) begin
            w_state_nxt = S_DONE;
          end else if (w_reject) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (w_rd_en && (r_remaining == 32'd1)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Finish on the cycle of the last handshake so done lands directly
        // after the final stream word.
        if (!r_inflight &&
            ((r_count == '0) || ((r_count == (c_PTR_W+1)'(1)) && w_pop))) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read pointer, remaining count and the one-deep in-flight tracker.
  // Clearing r_inflight on clr is what discards data returning after reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_rd_ptr    <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_accept) begin
        r_rd_ptr    <= w_base;
        r_remaining <= len_i;
      end else if (w_rd_en) begin
        r_rd_ptr    <= r_rd_ptr + MEM_AW'(1);
        r_remaining <= r_remaining - 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO. Storage carries no reset; only the pointers and count do.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      r_count <= r_count + (c_PTR_W+1)'(w_push) - (c_PTR_W+1)'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_boot_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_reader
// Purpose  : Self-checking bench for boot_reader. A behavioural 1-cycle
//            memory returns a known pattern per address; expected stream
//            words are queued when a transfer is started and popped on every
//            stream handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_reader;

  localparam int MEM_AW = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [7:0]  addr_i;
  logic [31:0] len_i;
  logic        busy;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  boot_reader_if #(.MEM_AW(MEM_AW), .DATA_W(DATA_W)) bus ();

  boot_reader #(
    .MEM_AW(MEM_AW), .DATA_W(DATA_W), .BLK_SHIFT(8), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .addr_i(addr_i), .len_i(len_i),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Fixed-latency memory; junk is returned on cycles without a read.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem_word(bus.mem_addr);
    else               bus.mem_rdata <= $urandom;
  end

  // One transfer from start to idle, checking addresses, data order, stall
  // stability, occupancy bound and completion timing. mode 0: ready always
  // high; mode 1: ready high one cycle in three. poke: pulse start mid-run.
  task automatic do_transfer(input logic [7:0] a, input logic [31:0] n,
                             input int mode, input bit poke, input string name);
    logic [15:0] base;
    bit          rejected;
    int          k, issued, popped, n_done, n_err, done_k, err_k, end_k;
    int          first_rd, first_v, busy_low_k, exp_end;
    bit          prev_stall;
    logic [31:0] prev_data, exp_w;
    base       = {a, 8'h00};
    rejected   = ((34'(base) + 34'(n)) > 34'h10000);
    k = 0; issued = 0; popped = 0; n_done = 0; n_err = 0;
    done_k = -1; err_k = -1; first_rd = -1; first_v = -1; busy_low_k = -1;
    prev_stall = 1'b0; prev_data = '0;
    if (!rejected) for (int i = 0; i < int'(n); i++) sb.push_back(mem_word(base + 16'(i)));
    while (1) begin
      @(negedge clk);
      start = (k == 0) || (poke && (k == 5));
      if (k == 0) begin addr_i = a; len_i = n; end
      else if (poke && (k == 5)) begin addr_i = 8'h07; len_i = 32'd9; end
      bus.dout_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      #1;
      if (k >= 1 && !busy && busy_low_k < 0) busy_low_k = k;
      if (done) begin n_done++; if (done_k < 0) done_k = k; end
      if (err)  begin n_err++;  if (err_k < 0) err_k = k; end
      if (bus.mem_rd_en) begin
        if (first_rd < 0) first_rd = k;
        n_checks++;
        if ((issued - popped) >= DEPTH) begin
          n_fail++;
          $display("FAIL %s occupancy: read issued with %0d words held, limit %0d", name, issued - popped, DEPTH);
        end
        n_checks++;
        if (bus.mem_addr !== base + 16'(issued)) begin
          n_fail++;
          $display("FAIL %s mem_addr: got %h want %h", name, bus.mem_addr, base + 16'(issued));
        end
        issued++;
      end
      if (prev_stall) begin
        n_checks++;
        if ({bus.dout_valid, bus.dout_data} !== {1'b1, prev_data}) begin
          n_fail++;
          $display("FAIL %s stall_hold: got v=%b d=%h want v=1 d=%h", name, bus.dout_valid, bus.dout_data, prev_data);
        end
      end
      prev_stall = 1'b0;
      if (bus.dout_valid) begin
        if (first_v < 0) first_v = k;
        if (bus.dout_ready) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s extra_word: got %h want no word", name, bus.dout_data);
          end else begin
            exp_w = sb.pop_front();
            if (bus.dout_data !== exp_w) begin
              n_fail++;
              $display("FAIL %s dout_data: got %h want %h", name, bus.dout_data, exp_w);
            end
          end
          popped++;
        end else begin
          prev_stall = 1'b1;
          prev_data  = bus.dout_data;
        end
      end
      k++;
      if (busy_low_k > 0 && k > busy_low_k + 2) break;
      if (k > 3000) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout: got no idle after %0d cycles want idle", name, k);
        break;
      end
    end
    start = 1'b0;
    exp_end = (rejected || n == 0) ? 0 : int'(n);
    end_k   = rejected ? err_k : done_k;
    n_checks++;
    if (issued != exp_end) begin
      n_fail++; $display("FAIL %s read_count: got %0d want %0d", name, issued, exp_end);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL %s words_missing: got %0d left want 0", name, sb.size());
      sb.delete();
    end
    n_checks++;
    if ({n_done, n_err} != {32'(rejected ? 0 : 1), 32'(rejected ? 1 : 0)}) begin
      n_fail++; $display("FAIL %s pulses: got done=%0d err=%0d want done=%0d err=%0d", name, n_done, n_err, rejected ? 0 : 1, rejected ? 1 : 0);
    end
    n_checks++;
    if (busy_low_k != end_k + 1) begin
      n_fail++; $display("FAIL %s busy_low: got %0d want %0d", name, busy_low_k, end_k + 1);
    end
    if (mode == 0) begin
      n_checks++;
      if (end_k != ((exp_end == 0) ? 1 : exp_end + 3)) begin
        n_fail++; $display("FAIL %s end_cycle: got %0d want %0d", name, end_k, (exp_end == 0) ? 1 : exp_end + 3);
      end
      if (exp_end != 0) begin
        n_checks++;
        if ({first_rd, first_v} != {32'd1, 32'd3}) begin
          n_fail++; $display("FAIL %s latency: got rd=%0d v=%0d want rd=1 v=3", name, first_rd, first_v);
        end
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; addr_i = '0; len_i = '0; bus.dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, err, bus.mem_rd_en, bus.dout_valid, bus.mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0", {busy, done, err, bus.mem_rd_en, bus.dout_valid, bus.mem_addr});
    end
  endtask

  task automatic test_stream();         do_transfer(8'h03, 32'd400, 0, 1'b0, "stream");       endtask
  task automatic test_backpressure();   do_transfer(8'h03, 32'd400, 1, 1'b0, "backpressure"); endtask
  task automatic test_zero_len();       do_transfer(8'h05, 32'd0,   0, 1'b0, "zero_len");     endtask
  task automatic test_reject();         do_transfer(8'hFF, 32'd257, 0, 1'b0, "reject");       endtask
  task automatic test_top_boundary();   do_transfer(8'hFF, 32'd256, 0, 1'b0, "top_boundary"); endtask
  task automatic test_start_ignored();  do_transfer(8'h10, 32'd30,  0, 1'b1, "restart");      endtask

  task automatic test_clr();
    int popped = 0;
    int k = 0;
    logic [31:0] exp_w;
    for (int i = 0; i < 100; i++) sb.push_back(mem_word(16'h2000 + 16'(i)));
    while (popped < 10 && k < 200) begin
      @(negedge clk);
      start = (k == 0); addr_i = 8'h20; len_i = 32'd100; bus.dout_ready = 1'b1;
      #1;
      if (bus.dout_valid) begin
        exp_w = sb.pop_front();
        n_checks++;
        if (bus.dout_data !== exp_w) begin
          n_fail++; $display("FAIL clr_pre dout_data: got %h want %h", bus.dout_data, exp_w);
        end
        popped++;
      end
      k++;
    end
    sb.delete();
    @(negedge clk);
    start = 1'b0; clr = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL clr_inflight: got rd_en=%b want 1", bus.mem_rd_en);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, err, bus.mem_rd_en, bus.dout_valid, bus.mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL clr_outputs: got %b want 0", {busy, done, err, bus.mem_rd_en, bus.dout_valid, bus.mem_addr});
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({busy, bus.dout_valid} !== 2'b00) begin
        n_fail++; $display("FAIL clr_stale: got busy=%b valid=%b want 0 0", busy, bus.dout_valid);
      end
    end
    do_transfer(8'h01, 32'd4, 0, 1'b0, "clr_restart");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_len();
    test_reject();
    test_top_boundary();
    test_clr();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_reader.md
# boot_reader

Readback engine for the PMU boot path: takes a bitstream descriptor (8-bit block address, 32-bit word length) of the form the bootloader table stores, and streams those words out of boot memory. It issues sequential single-word reads to a fixed-latency memory and delivers the data on a valid/ready stream to the configuration loader. An internal FIFO absorbs the memory latency and downstream backpressure.

## Interface
- MEM_AW, 16, boot memory word-address width
- DATA_W, 32, memory/stream data width
- BLK_SHIFT, 8, log2 of words per block; start word address = addr_i << BLK_SHIFT
- DEPTH, 4, output FIFO depth in words (power of 2, >= 2)

- clk  in  1  single clock, all logic on rising edge
- clr  in  1  reset, synchronous, active-high
- start  in  1  request a transfer; sampled only in IDLE
- addr_i  in  8  descriptor block address
- len_i  in  32  descriptor length in words
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at normal completion
- err  out  1  one-cycle pulse when a descriptor is rejected
- mem_rd_en  out  1  read strobe, one word per asserted cycle
- mem_addr  out  MEM_AW  read word address, valid with mem_rd_en
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- dout_valid  out  1  stream word available
- dout_data  out  DATA_W  stream word
- dout_ready  in  1  consumer accepts; transfer when valid & ready

## Operation
- States: IDLE, FETCH, DRAIN, DONE, ERR.
- IDLE: on start, latch base = addr_i << BLK_SHIFT (MEM_AW bits, zero-extended, upper bits dropped only if BLK_SHIFT+8 > MEM_AW) and len_i.
  - len_i == 0 -> DONE (no reads, no stream words).
  - base + len_i > 2^MEM_AW (34-bit compare) -> ERR (no reads).
  - otherwise -> FETCH; rd_ptr = base, remaining = len_i, sent = 0.
- FETCH: assert mem_rd_en when remaining != 0 and (fifo_count + inflight) < DEPTH; same-cycle pop is not credited. On issue: mem_addr = rd_ptr, rd_ptr += 1, remaining -= 1. When remaining reaches 0 -> DRAIN.
- Return path: inflight is a 1-bit flag set by mem_rd_en; the next cycle mem_rdata is pushed into the FIFO. FIFO never overflows by construction.
- Stream: dout_valid = fifo not empty; dout_data = FIFO head; pop on valid & ready. Words in ascending address order. dout_data is don't-care when dout_valid = 0.
- DRAIN: wait until FIFO empty and inflight = 0 after the last handshake -> DONE.
- DONE: done = 1 for one cycle -> IDLE. ERR: err = 1 for one cycle -> IDLE.
- start outside IDLE is ignored; addr_i/len_i are sampled only with an accepted start.
- clr (any state): state = IDLE, FIFO flushed, inflight cleared, counters zero; read data returning the cycle after clr is discarded.

## Timing
- Reset values: busy 0, done 0, err 0, mem_rd_en 0, mem_addr 0, dout_valid 0.
- start accepted in cycle t: busy from t+1; first mem_rd_en at t+1; first dout_valid at t+3.
- With dout_ready held high and DEPTH >= 3: one read per cycle, one word out per cycle after the initial 2-cycle latency; N words finish with done at t+N+3.
- DEPTH = 2: sustained rate is 2 words per 3 cycles.
- len 0: done at t+1. Rejected descriptor: err at t+1. busy is high in the done/err cycle and low the cycle after.
- dout_valid, once high, stays high with dout_data stable until the handshake.

## Test plan
- addr_i=3, len_i=400, ready always 1 -> mem_addr 0x0300..0x048F each once, 400 words in order, done at t+403, busy low at t+404.
- Same descriptor, dout_ready toggling 1-on/2-off -> no word lost or duplicated, dout_data stable while stalled, fifo_count + inflight never exceeds DEPTH, mem_rd_en stops while full.
- len_i=0 -> done at t+1, no mem_rd_en, no dout_valid, err stays 0.
- addr_i=0xFF, len_i=257 (base 0xFF00, end 0x10001 > 2^16) -> err at t+1, no reads, done stays 0. Then addr_i=0xFF, len_i=256 -> accepted, last address 0xFFFF, done.
- clr asserted mid-transfer after 10 words with a read in flight -> next cycle all outputs at reset values, stale mem_rdata not emitted; a new start with addr_i=1, len_i=4 streams addresses 0x0100..0x0103 only.
- start pulsed again while busy -> ignored; transfer completes exactly once with the original descriptor.
